// File: rtl/crossroad_event_generator.sv
// crossroad_event_generator
//   Front-end event stage for the crossroad design. Five button channels
//   (four lane buttons plus the manual switch) are synchronised, debounced
//   and turned into single-cycle press events. Two timers generate the
//   periodic light-phase change and the car-cross tick.
//
// Parameters
//   DEBOUNCE_CYCLES     stable cycles needed to accept a button level (>= 2)
//   CROSS_PERIOD_CYCLES car-cross tick period in cycles (>= 2)
//   PHASE_CYCLES        automatic phase-change period in cycles (>= 2)
//
// Ports
//   clk                       system clock
//   rst                       synchronous, active-high reset
//   run                       level; lets the phase and cross timers advance
//   btn_a1/a2/b1/b2           raw asynchronous lane buttons (high = pressed)
//   btn_switch                raw asynchronous manual phase-change button
//   car_arrived_a1/a2/b1/b2   one-cycle pulse per accepted lane press
//   crossroad_status_changed  one-cycle phase-change pulse
//   signal_car_to_cross       one-cycle car-cross tick
module crossroad_event_generator #(
  parameter int unsigned DEBOUNCE_CYCLES     = 1_000_000,
  parameter int unsigned CROSS_PERIOD_CYCLES = 100_000_000,
  parameter int unsigned PHASE_CYCLES        = 500_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic btn_a1,
  input  logic btn_a2,
  input  logic btn_b1,
  input  logic btn_b2,
  input  logic btn_switch,
  output logic car_arrived_a1,
  output logic car_arrived_a2,
  output logic car_arrived_b1,
  output logic car_arrived_b2,
  output logic crossroad_status_changed,
  output logic signal_car_to_cross
);

  localparam int unsigned NCH = 5;
  localparam int unsigned SW  = 4;  // channel index of btn_switch

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned PW = $clog2(PHASE_CYCLES);
  localparam int unsigned CW = $clog2(CROSS_PERIOD_CYCLES);

  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PHASE_LAST = PW'(PHASE_CYCLES - 1);
  localparam logic [CW-1:0] CROSS_LAST = CW'(CROSS_PERIOD_CYCLES - 1);

  // ---------------------------------------------------------------------
  // Button channels
  // ---------------------------------------------------------------------
  logic [NCH-1:0] raw;
  logic [NCH-1:0] sync1_q, sync2_q;
  logic [NCH-1:0] deb_q, deb_d;
  logic [NCH-1:0] deb_prev_q;
  logic [NCH-1:0] rise;
  logic [DW-1:0]  dcnt_q [NCH];
  logic [DW-1:0]  dcnt_d [NCH];
  logic [3:0]     lane_pulse_q;

  assign raw = {btn_switch, btn_b2, btn_b1, btn_a2, btn_a1};

  // Counter clears whenever synced and debounced levels agree, so any
  // disagreement must persist DEBOUNCE_CYCLES consecutive cycles to win.
  always_comb begin
    deb_d = deb_q;
    for (int unsigned i = 0; i < NCH; i++) begin
      dcnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (dcnt_q[i] == DEB_LAST) begin
          deb_d[i] = sync2_q[i];
        end else begin
          dcnt_d[i] = dcnt_q[i] + DW'(1);
        end
      end
    end
  end

  // Combinational rising edge of the debounced level; the lane outputs
  // register it, and the switch channel feeds the phase logic which is
  // itself registered, so both paths see the same latency.
  assign rise = deb_q & ~deb_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      deb_q        <= '0;
      deb_prev_q   <= '0;
      lane_pulse_q <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        dcnt_q[i] <= '0;
      end
    end else begin
      sync1_q      <= raw;
      sync2_q      <= sync1_q;
      deb_q        <= deb_d;
      deb_prev_q   <= deb_q;
      lane_pulse_q <= rise[3:0];
      for (int unsigned i = 0; i < NCH; i++) begin
        dcnt_q[i] <= dcnt_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Phase and cross timers
  // ---------------------------------------------------------------------
  logic [PW-1:0] phase_q, phase_d;
  logic [CW-1:0] cross_q, cross_d;
  logic          phase_evt, cross_hit;
  logic          status_q, cross_tick_q;

  always_comb begin
    phase_evt = (run && (phase_q == PHASE_LAST)) || rise[SW];
    cross_hit = run && (cross_q == CROSS_LAST);

    phase_d = phase_q;
    if (phase_evt) begin
      phase_d = '0;
    end else if (run) begin
      phase_d = phase_q + PW'(1);
    end

    // A phase event re-phases the cross timer as well.
    cross_d = cross_q;
    if (phase_evt || cross_hit) begin
      cross_d = '0;
    end else if (run) begin
      cross_d = cross_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q      <= '0;
      cross_q      <= '0;
      status_q     <= 1'b0;
      cross_tick_q <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      cross_q      <= cross_d;
      status_q     <= phase_evt;
      // No car crosses in the cycle the lights switch.
      cross_tick_q <= cross_hit && !phase_evt;
    end
  end

  assign car_arrived_a1           = lane_pulse_q[0];
  assign car_arrived_a2           = lane_pulse_q[1];
  assign car_arrived_b1           = lane_pulse_q[2];
  assign car_arrived_b2           = lane_pulse_q[3];
  assign crossroad_status_changed = status_q;
  assign signal_car_to_cross      = cross_tick_q;

endmodule
